// File: rtl/csc_cfg_ctrl.sv
// rtl/csc_cfg_ctrl.sv - RGB->YCbCr coefficient controller with frame-aligned shadow/active update
module csc_cfg_ctrl #(
  parameter int COEF_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RGB_vsync,
  input  logic                  cfg_wr,
  input  logic                  cfg_rd,
  input  logic [3:0]            cfg_addr,
  input  logic [7:0]            cfg_wdata,
  input  logic                  cfg_commit,
  output logic [7:0]            cfg_rdata,
  output logic [9*COEF_W-1:0]   coef_bus,
  output logic                  csc_bypass,
  output logic                  cfg_pending,
  output logic                  upd_done,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_APPLY} state_t;

  localparam logic [7:0] BT601 [9] = '{8'd77, 8'd150, 8'd29, 8'd43, 8'd85, 8'd128, 8'd128, 8'd107, 8'd21};
  localparam logic [7:0] BT709 [9] = '{8'd54, 8'd183, 8'd18, 8'd29, 8'd99, 8'd128, 8'd128, 8'd116, 8'd12};

  state_t              r_state;
  logic                r_vs_d;
  logic [COEF_W-1:0]   r_sh_coef [9];
  logic [1:0]          r_sh_mode;
  logic                r_sh_byp;
  logic [1:0]          r_act_mode;

  logic [COEF_W-1:0]   w_sh_coef_nxt [9];
  logic [1:0]          w_sh_mode_nxt;
  logic                w_sh_byp_nxt;
  logic                w_err_set;
  logic                w_edge;
  logic [9*COEF_W-1:0] w_new_bus;
  logic [7:0]          w_rd_val;

  assign w_edge = RGB_vsync & ~r_vs_d;

  // Shadow as it stands after this cycle's write; APPLY loads from this so a same-cycle write lands.
  always_comb begin
    w_sh_coef_nxt = r_sh_coef;
    w_sh_mode_nxt = r_sh_mode;
    w_sh_byp_nxt  = r_sh_byp;
    w_err_set     = 1'b0;
    if (cfg_wr) begin
      for (int i = 0; i < 9; i++) begin
        if (cfg_addr == 4'(i)) w_sh_coef_nxt[i] = COEF_W'(cfg_wdata);
      end
      if (cfg_addr == 4'd9) begin
        w_sh_byp_nxt = cfg_wdata[2];
        if (cfg_wdata[1:0] == 2'd3) w_err_set = 1'b1;
        else                        w_sh_mode_nxt = cfg_wdata[1:0];
      end
    end
  end

  always_comb begin
    w_new_bus = '0;
    for (int i = 0; i < 9; i++) begin
      case (w_sh_mode_nxt)
        2'd0:    w_new_bus[(8-i)*COEF_W +: COEF_W] = COEF_W'(BT601[i]);
        2'd1:    w_new_bus[(8-i)*COEF_W +: COEF_W] = COEF_W'(BT709[i]);
        default: w_new_bus[(8-i)*COEF_W +: COEF_W] = w_sh_coef_nxt[i];
      endcase
    end
  end

  // Readback always reflects the active set, which a same-cycle write cannot touch.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < 9; i++) begin
      if (cfg_addr == 4'(i)) w_rd_val = 8'(coef_bus[(8-i)*COEF_W +: COEF_W]);
    end
    if (cfg_addr == 4'd9) w_rd_val = {5'b0, csc_bypass, r_act_mode};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vs_d      <= 1'b0;
      r_sh_mode   <= 2'd0;
      r_sh_byp    <= 1'b0;
      r_act_mode  <= 2'd0;
      cfg_rdata   <= '0;
      csc_bypass  <= 1'b0;
      cfg_pending <= 1'b0;
      upd_done    <= 1'b0;
      cfg_err     <= 1'b0;
      frame_cnt   <= '0;
      for (int i = 0; i < 9; i++) begin
        r_sh_coef[i]                      <= COEF_W'(BT601[i]);
        coef_bus[(8-i)*COEF_W +: COEF_W]  <= COEF_W'(BT601[i]);
      end
    end else begin
      r_vs_d    <= RGB_vsync;
      r_sh_coef <= w_sh_coef_nxt;
      r_sh_mode <= w_sh_mode_nxt;
      r_sh_byp  <= w_sh_byp_nxt;
      upd_done  <= 1'b0;
      if (w_edge) frame_cnt <= frame_cnt + 1'b1;
      if (cfg_rd) cfg_rdata <= w_rd_val;
      if (w_err_set)                           cfg_err <= 1'b1;
      else if (cfg_commit && r_state == S_IDLE) cfg_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cfg_commit) begin
            r_state     <= S_ARMED;
            cfg_pending <= 1'b1;
          end
        end
        S_ARMED: begin
          if (w_edge) r_state <= S_APPLY;
        end
        S_APPLY: begin
          r_state     <= S_IDLE;
          cfg_pending <= 1'b0;
          coef_bus    <= w_new_bus;
          csc_bypass  <= w_sh_byp_nxt;
          r_act_mode  <= w_sh_mode_nxt;
          upd_done    <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csc_cfg_ctrl.sv
// tb/tb_csc_cfg_ctrl.sv - scoreboard bench for csc_cfg_ctrl
module tb_csc_cfg_ctrl;

  localparam int CW = 8;
  localparam int NW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            RGB_vsync = 1'b0;
  logic            cfg_wr = 1'b0;
  logic            cfg_rd = 1'b0;
  logic [3:0]      cfg_addr = '0;
  logic [7:0]      cfg_wdata = '0;
  logic            cfg_commit = 1'b0;
  logic [7:0]      cfg_rdata;
  logic [9*CW-1:0] coef_bus;
  logic            csc_bypass;
  logic            cfg_pending;
  logic            upd_done;
  logic            cfg_err;
  logic [NW-1:0]   frame_cnt;

  csc_cfg_ctrl #(.COEF_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .RGB_vsync(RGB_vsync),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_rdata(cfg_rdata), .coef_bus(coef_bus),
    .csc_bypass(csc_bypass), .cfg_pending(cfg_pending), .upd_done(upd_done),
    .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_upd = 0;

  logic [7:0]  P601 [9] = '{77, 150, 29, 43, 85, 128, 128, 107, 21};
  logic [7:0]  P709 [9] = '{54, 183, 18, 29, 99, 128, 128, 116, 12};

  logic [7:0]  m_sh [9];
  logic [1:0]  m_mode;
  logic        m_byp;
  logic        m_armed;
  logic [7:0]  m_act [9];
  logic [1:0]  m_act_mode;
  logic        m_act_byp;
  int          m_frames;

  logic [72:0] upd_q [$];
  logic [7:0]  rd_q [$];
  logic        rd_d = 1'b0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] act_bus();
    logic [71:0] b;
    for (int i = 0; i < 9; i++) b[(8-i)*8 +: 8] = m_act[i];
    return b;
  endfunction

  function automatic logic [71:0] p601_bus();
    logic [71:0] b;
    for (int i = 0; i < 9; i++) b[(8-i)*8 +: 8] = P601[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_sh[i]  = P601[i];
      m_act[i] = P601[i];
    end
    m_mode = 0; m_byp = 0; m_armed = 0;
    m_act_mode = 0; m_act_byp = 0; m_frames = 0;
    upd_q.delete();
    rd_q.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(posedge clk) rd_d <= cfg_rd;

  always @(negedge clk) begin
    if (!rst && upd_done) begin
      n_upd++;
      if (upd_q.size() == 0) check("upd_unexpected", 80'(upd_done), 80'(0));
      else check("upd_bus", {7'b0, csc_bypass, coef_bus}, {7'b0, upd_q.pop_front()});
    end
    if (!rst && rd_d) begin
      if (rd_q.size() == 0) check("rd_unexpected", 80'(rd_d), 80'(0));
      else check("rd_data", 80'(cfg_rdata), 80'(rd_q.pop_front()));
    end
  end

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    if (a <= 4'd8) return m_act[a];
    if (a == 4'd9) return {5'b0, m_act_byp, m_act_mode};
    return 8'd0;
  endfunction

  task automatic model_wr(input logic [3:0] a, input logic [7:0] d);
    if (a <= 4'd8) m_sh[a] = d;
    else if (a == 4'd9) begin
      m_byp = d[2];
      if (d[1:0] != 2'd3) m_mode = d[1:0];
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_wr = 1; cfg_addr = a; cfg_wdata = d;
    model_wr(a, d);
    tick();
    cfg_wr = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    cfg_rd = 1; cfg_addr = a;
    rd_q.push_back(exp_rd(a));
    tick();
    cfg_rd = 0;
  endtask

  task automatic wr_rd(input logic [3:0] a, input logic [7:0] d);
    cfg_wr = 1; cfg_rd = 1; cfg_addr = a; cfg_wdata = d;
    rd_q.push_back(exp_rd(a));
    model_wr(a, d);
    tick();
    cfg_wr = 0; cfg_rd = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    if (!m_armed) m_armed = 1;
    tick();
    cfg_commit = 0;
  endtask

  task automatic apply_model();
    for (int i = 0; i < 9; i++)
      m_act[i] = (m_mode == 0) ? P601[i] : (m_mode == 1) ? P709[i] : m_sh[i];
    m_act_mode = m_mode;
    m_act_byp  = m_byp;
  endtask

  task automatic vsync_pulse();
    logic        applying;
    logic [71:0] old_bus;
    applying = m_armed;
    old_bus  = act_bus();
    RGB_vsync = 1;
    m_frames++;
    if (applying) begin
      apply_model();
      m_armed = 0;
      upd_q.push_back({m_act_byp, act_bus()});
    end
    tick();
    if (applying) begin
      check("lat1_upd", 80'(upd_done), 80'(0));
      check("lat1_bus", 80'(coef_bus), 80'(old_bus));
    end
    tick();
    if (applying) begin
      check("lat2_upd", 80'(upd_done), 80'(1));
      check("lat2_bus", 80'(coef_bus), 80'(act_bus()));
      check("lat2_pend", 80'(cfg_pending), 80'(0));
    end
    tick();
    if (applying) check("upd_one_cycle", 80'(upd_done), 80'(0));
    RGB_vsync = 0;
    tick();
    check("frame_cnt", 80'(frame_cnt), 80'(8'(m_frames)));
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    #2;
    check("rst_bus", 80'(coef_bus), 80'(p601_bus()));
    check("rst_byp", 80'(csc_bypass), 80'(0));
    check("rst_pend", 80'(cfg_pending), 80'(0));
    check("rst_err", 80'(cfg_err), 80'(0));
    check("rst_fcnt", 80'(frame_cnt), 80'(0));
    check("rst_upd", 80'(upd_done), 80'(0));
    check("rst_rdata", 80'(cfg_rdata), 80'(0));
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    int base;
    model_reset();
    tick();
    do_reset();

    // reserved mode: error flag, mode retained, cleared by next commit
    wr(4'h9, 8'h03);
    tick();
    check("err_set", 80'(cfg_err), 80'(1));
    commit();
    check("err_clr", 80'(cfg_err), 80'(0));
    vsync_pulse();
    rd(4'h9);
    rd(4'h0);
    tick();

    // BT.709 with a long wait before the frame edge
    wr(4'h9, 8'h01);
    commit();
    repeat (100) tick();
    check("wait_bus", 80'(coef_bus), 80'(p601_bus()));
    check("wait_pend", 80'(cfg_pending), 80'(1));
    vsync_pulse();
    rd(4'h1);
    rd(4'h8);

    // custom coefficients with bypass
    for (int i = 0; i < 9; i++) wr(4'(i), 8'(i + 1));
    wr(4'h9, 8'h06);
    rd(4'h4);
    commit();
    vsync_pulse();
    check("cust_byp", 80'(csc_bypass), 80'(1));
    rd(4'h4);
    rd(4'h9);
    rd(4'hA);
    wr_rd(4'h9, 8'h00);
    tick();

    // commit coincident with frame edge waits a frame; second commit ignored
    base = n_upd;
    cfg_commit = 1; RGB_vsync = 1;
    m_armed = 1; m_frames++;
    tick();
    cfg_commit = 0;
    tick(); tick();
    RGB_vsync = 0;
    tick();
    check("coinc_pend", 80'(cfg_pending), 80'(1));
    check("coinc_noupd", 80'(n_upd - base), 80'(0));
    commit();
    vsync_pulse();
    check("single_upd", 80'(n_upd - base), 80'(1));
    rd(4'h9);

    // reset while armed drops the commit
    wr(4'h9, 8'h05);
    commit();
    check("armed_pend", 80'(cfg_pending), 80'(1));
    base = n_upd;
    do_reset();
    vsync_pulse();
    check("rst_no_upd", 80'(n_upd - base), 80'(0));
    check("rst_bus_after", 80'(coef_bus), 80'(p601_bus()));

    // frame counter wrap
    do_reset();
    for (int i = 0; i < (1 << NW) + 1; i++) begin
      RGB_vsync = 1; tick();
      RGB_vsync = 0; tick();
    end
    tick();
    check("frame_wrap", 80'(frame_cnt), 80'(1));

    tick();
    check("upd_q_empty", 80'(upd_q.size()), 80'(0));
    check("rd_q_empty", 80'(rd_q.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/csc_cfg_ctrl.md
Name: csc_cfg_ctrl

Overview:
Configuration controller for the RGB→YCbCr conversion pipeline. Holds a shadow coefficient set written by a host register interface and drives the active coefficient bus and bypass flag to the conversion datapath. The active set changes only at a frame boundary (RGB_vsync rising edge), so no frame is converted with mixed coefficients. Also provides readback, a frame counter and status.

Parameters:
COEF_W, 8, width of each conversion coefficient (Q0.8 magnitude; datapath signs are fixed).
CNT_W, 16, frame counter width.

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
RGB_vsync  in  1  RGB frame sync, same signal that feeds the conversion datapath
cfg_wr  in  1  host write strobe, one cycle per write
cfg_rd  in  1  host read strobe
cfg_addr  in  4  register address
cfg_wdata  in  8  write data
cfg_commit  in  1  one-cycle pulse: arm shadow→active transfer at next frame boundary
cfg_rdata  out  8  read data, valid the cycle after cfg_rd
coef_bus  out  9*COEF_W  active coefficients {kYR,kYG,kYB,kCbR,kCbG,kCbB,kCrR,kCrG,kCrB}, kYR in MSBs
csc_bypass  out  1  active bypass flag (datapath passes RGB unchanged)
cfg_pending  out  1  high while a commit is armed and not yet applied
upd_done  out  1  one-cycle pulse on the cycle the active set changes
cfg_err  out  1  sticky: reserved mode written
frame_cnt  out  CNT_W  count of RGB_vsync rising edges, wraps

Behaviour:
- Register map, shadow side: 0x0–0x8 custom coefficients in coef_bus order; 0x9 = {5'b0, bypass, mode[1:0]}; 0xA–0xF reserved (writes ignored, read 0).
- Modes: 0 BT.601 {77,150,29,43,85,128,128,107,21}; 1 BT.709 {54,183,18,29,99,128,128,116,12}; 2 custom (shadow 0x0–0x8); 3 reserved.
- Writing mode 3: mode field keeps its old value, bypass bit still updates, cfg_err set. cfg_err clears on the next accepted cfg_commit.
- Reads return the ACTIVE value, not the shadow. 0x0–0x8 return the active coefficient for the active mode (preset or custom). 0x9 returns the active bypass/mode. cfg_rdata holds its last value when cfg_rd is low.
- If cfg_wr and cfg_rd are high in the same cycle, both are serviced; the read returns the pre-write active value.
- Vsync edge: vs_d is a registered copy of RGB_vsync; edge = RGB_vsync & ~vs_d. frame_cnt increments on the clock following edge detection and wraps from all-ones to 0.
- FSM:
  - IDLE: cfg_commit → ARMED.
  - ARMED: edge → APPLY. Further cfg_commit pulses have no effect. Writes are still accepted into the shadow.
  - APPLY: one cycle. The active set is loaded from the shadow as it stands at the end of this cycle, so a write in the APPLY cycle is included. Then → IDLE.
- Update timing:
  - coef_bus and csc_bypass change on the clock leaving APPLY, and upd_done is high for exactly that cycle.
  - Latency from the first cycle RGB_vsync is high to the new coef_bus is 2 clocks.
  - Since blanking, not de, is guaranteed during vsync, this lands within the blanking interval.
- cfg_pending = (state != IDLE).
- If cfg_commit arrives in the same cycle as an edge while in IDLE, the FSM goes to ARMED only; the update waits for the following frame.
- Reset (async, active-high), all outputs and state:
  - state IDLE; vs_d 0; frame_cnt 0; cfg_rdata 0; upd_done 0; cfg_err 0.
  - Shadow and active: mode 0, bypass 0, custom coefficients reset to the BT.601 values. coef_bus therefore shows BT.601 immediately.
  - Reset mid-ARMED drops the pending commit.
- All outputs are registered.

Test Plan:
- Reset → coef_bus = {77,150,29,43,85,128,128,107,21}, csc_bypass = 0, cfg_pending = 0, frame_cnt = 0, cfg_err = 0.
- Write 0x9 = 0x01, pulse commit, no vsync for 100 cycles → coef_bus unchanged, cfg_pending = 1. Raise RGB_vsync → 2 clocks later coef_bus = BT.709 set, upd_done = 1 for 1 cycle, cfg_pending = 0.
- Custom path: write 0x0–0x8 = 1..9, then 0x9 = 0x06 (mode 2, bypass 1), commit, vsync edge → coef_bus = {1,…,9}, csc_bypass = 1. Read 0x4 → 5 the next cycle.
- Write 0x9 = 0x03 → cfg_err = 1, mode is still 0 after a commit/vsync. The next commit clears cfg_err.
- Commit coincident with a vsync edge in IDLE → no update this frame; the update and upd_done occur after the next vsync edge. A second commit while ARMED → a single upd_done only.
- Assert rst while ARMED → BT.601 active, cfg_pending = 0, and no upd_done on the following vsync. Also run 2^CNT_W + 1 vsync edges → frame_cnt = 1.
